// File: rtl/seg7_display_driver.sv
// seg7_display_driver: signed result to BCD (shift-add-3),
// then 4-digit multiplexed scan onto active-low an/seg pins.
module seg7_display_driver #(
  parameter int DATA_W      = 8,
  parameter int REFRESH_CNT = 100000
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic              err,
  output logic              busy,
  output logic [3:0]        an,
  output logic [7:0]        seg
);

  localparam int CNT_W = (REFRESH_CNT > 1) ?
                         $clog2(REFRESH_CNT) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  function automatic logic [6:0] enc_digit(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  // hundreds never exceeds 5, so 3 bits suffice
  logic [10:0]       bcd_q, bcd_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [3:0][6:0]   disp_q, disp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic [DATA_W-1:0] mag;
  logic [3:0]        adj_t, adj_u;
  logic [3:0]        hund;
  logic [3:0][6:0]   result;

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;

  // magnitude of the incoming value; -2^(N-1) maps exactly
  always_comb begin
    mag = value[DATA_W-1] ? -value : value;
  end

  // add-3 correction for tens and units before each shift
  always_comb begin
    adj_t = bcd_q[7:4];
    adj_u = bcd_q[3:0];
    if (bcd_q[7:4] >= 4'd5) adj_t = bcd_q[7:4] + 4'd3;
    if (bcd_q[3:0] >= 4'd5) adj_u = bcd_q[3:0] + 4'd3;
  end

  // finished BCD (or error) turned into digit patterns
  always_comb begin
    hund = {1'b0, bcd_q[10:8]};
    if (err_q) begin
      result = {SEG_BLANK, SEG_E, SEG_R, SEG_R};
    end else begin
      result[3] = neg_q ? SEG_MINUS : SEG_BLANK;
      result[2] = (hund != 4'd0) ?
                  enc_digit(hund) : SEG_BLANK;
      result[1] = (hund != 4'd0 || bcd_q[7:4] != 4'd0) ?
                  enc_digit(bcd_q[7:4]) : SEG_BLANK;
      result[0] = enc_digit(bcd_q[3:0]);
    end
  end

  // converter FSM next state: accept, shift, commit
  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    neg_d   = neg_q;
    err_d   = err_q;
    busy_d  = busy_q;
    disp_d  = disp_q;
    unique case (state_q)
      IDLE: begin
        if (load && !busy_q) begin
          err_d   = err;
          neg_d   = value[DATA_W-1];
          bin_d   = mag;
          bcd_d   = '0;
          bits_d  = '0;
          busy_d  = 1'b1;
          state_d = err ? COMMIT : SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_q[9:8], adj_t, adj_u,
                          bin_q, 1'b0};
        bits_d = bits_q + BIT_W'(1);
        if (bits_q == BIT_W'(DATA_W - 1))
          state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = result;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // refresh counter, digit index and registered pin drive
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_CNT - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = {1'b1, disp_q[idx_q]};
  end

  // state registers; clear aborts conversion and blanks
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      bits_q  <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      disp_q  <= {4{SEG_BLANK}};
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: vector table + scoreboard
// for the BCD converter and digit scan.
module tb_seg7_display_driver;

  localparam int DW = 8;
  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] value;
  logic       load;
  logic       err;
  logic       busy;
  logic [3:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        e;
    logic [7:0]  v;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] segs;
    int          busy_n;
    string       name;
  } sb_t;

  sb_t         sbq[$];
  vec_t        vecs[10];
  logic [31:0] shown;

  seg7_display_driver #(
    .DATA_W(DW),
    .REFRESH_CNT(RC)
  ) dut (
    .clk(clk),
    .clear(clear),
    .value(value),
    .load(load),
    .err(err),
    .busy(busy),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic start_load(input logic e,
                            input logic [7:0] v,
                            input logic [31:0] exp,
                            input string nm);
    sb_t s;
    s.segs   = exp;
    s.busy_n = e ? 1 : DW + 1;
    s.name   = nm;
    sbq.push_back(s);
    load  = 1'b1;
    err   = e;
    value = v;
    step();
    load = 1'b0;
    err  = 1'b0;
  endtask

  task automatic collect_scan(input string nm,
                              input logic [31:0] exp);
    logic [31:0] got = '1;
    logic [3:0]  seen = '0;
    int          bz = 0;
    int          k;
    step();
    repeat (4 * RC) begin
      k = an_idx(an);
      if (k >= 0) begin
        got[k*8 +: 8] = seg;
        seen[k] = 1'b1;
      end
      if (busy) bz++;
      step();
    end
    check({nm, " seen"}, 32'(seen), 32'hF);
    check({nm, " idle"}, bz, 0);
    for (int d = 0; d < 4; d++)
      check($sformatf("%s d%0d", nm, d),
            32'(got[d*8 +: 8]), 32'(exp[d*8 +: 8]));
    shown = exp;
  endtask

  task automatic finish_load(input int n0);
    int  n = n0;
    int  bad = 0;
    int  k;
    sb_t s;
    while (busy && n < 40) begin
      k = an_idx(an);
      if (k >= 0 && seg !== shown[k*8 +: 8]) bad++;
      n++;
      step();
    end
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty got 0 want 1");
    end else begin
      s = sbq.pop_front();
      check({s.name, " busy_len"}, n, s.busy_n);
      check({s.name, " hold"}, bad, 0);
      collect_scan(s.name, s.segs);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd127, 32'hFFF9A4F8, "v127"};
    vecs[1] = '{1'b0, 8'hF6,  32'hBFFFF9C0, "vm10"};
    vecs[2] = '{1'b0, 8'h80,  32'hBFF9A480, "vm128"};
    vecs[3] = '{1'b0, 8'd5,   32'hFFFFFF92, "v5"};
    vecs[4] = '{1'b0, 8'd0,   32'hFFFFFFC0, "v0"};
    vecs[5] = '{1'b1, 8'h55,  32'hFF86AFAF, "verr"};
    vecs[6] = '{1'b0, 8'd100, 32'hFFF9C0C0, "v100"};
    vecs[7] = '{1'b0, 8'hFF,  32'hBFFFFFF9, "vm1"};
    vecs[8] = '{1'b0, 8'd9,   32'hFFFFFF90, "v9"};
    vecs[9] = '{1'b0, 8'd42,  32'hFFFF99A4, "v42"};

    shown = '1;
    clear = 1'b1;
    load  = 1'b0;
    err   = 1'b0;
    value = '0;
    step();
    step();
    check("rst an", 32'(an), 32'hF);
    check("rst seg", 32'(seg), 32'hFF);
    check("rst busy", 32'(busy), 0);
    clear = 1'b0;
    step();
    check("first an", 32'(an), 32'hE);
    collect_scan("post_rst", 32'hFFFFFFFF);

    for (int i = 0; i < 10; i++) begin
      start_load(vecs[i].e, vecs[i].v,
                 vecs[i].exp, vecs[i].name);
      finish_load(0);
    end

    start_load(1'b0, 8'd42, 32'hFFFF99A4, "ign99");
    step();
    step();
    load  = 1'b1;
    value = 8'd99;
    step();
    load = 1'b0;
    finish_load(3);

    start_load(1'b0, 8'd5, 32'hFFFFFF92, "v5b");
    finish_load(0);

    start_load(1'b0, 8'd42, 32'h0, "abort");
    void'(sbq.pop_back());
    step();
    step();
    step();
    @(posedge clk);
    #2 clear = 1'b1;
    #1;
    check("clr an", 32'(an), 32'hF);
    check("clr seg", 32'(seg), 32'hFF);
    check("clr busy", 32'(busy), 0);
    step();
    step();
    clear = 1'b0;
    step();
    check("clr first an", 32'(an), 32'hE);
    collect_scan("post_clr", 32'hFFFFFFFF);

    start_load(1'b0, 8'd7, 32'hFFFFFFF8, "v7");
    finish_load(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
